// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: fetch PC, icache requests, 2-entry decode queue
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   pc_nxt, redirect  branch/jump target from the PC control unit and its load strobe
//   pc                registered fetch PC exported to the PC control unit
//   icache_ren/addr   word read request toward the instruction cache
//   icache_rdata      returned instruction, valid when ren=1 and stall=0
//   icache_stall      cache busy; the request is held unchanged while high
//   if_valid/inst/pc  head of the queue toward decode
//   id_ready          decode consumes the head this cycle
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_nxt,
    input  logic        redirect,
    output logic [31:0] pc,
    output logic        icache_ren,
    output logic [29:0] icache_addr,
    input  logic [31:0] icache_rdata,
    input  logic        icache_stall,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] req_pc;
    logic        pend;       // a request was issued and stalled last cycle; it is still owed to the cache
    logic [1:0]  count;
    logic [31:0] e0_pc, e0_inst, e1_pc, e1_inst;

    logic        pop;
    logic        room;
    logic        complete;
    logic        push;
    logic        flush;
    logic        load_pc;
    logic [31:0] cur_req_pc;

    assign if_valid = (count != 2'd0);
    assign if_inst  = e0_inst;
    assign if_pc    = e0_pc;

    assign pop  = if_valid & id_ready;
    // A pop this cycle frees a slot before the return can be written, so a full queue may still issue.
    assign room = (count != 2'd2) | pop;

    // A fresh request is addressed from pc; a held request keeps the address latched when it was issued.
    assign cur_req_pc = pend ? req_pc : pc;

    always_comb begin
        state_nxt   = state;
        icache_ren  = 1'b0;
        icache_addr = pc[31:2];
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                if (pend) begin
                    icache_ren  = 1'b1;
                    icache_addr = req_pc[31:2];
                end else begin
                    icache_ren  = room;
                    icache_addr = pc[31:2];
                end
                // A redirect cannot withdraw a stalled request; wait it out in DRAIN.
                if (redirect && icache_ren && icache_stall)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                icache_ren  = 1'b1;
                icache_addr = req_pc[31:2];
                if (!icache_stall)
                    state_nxt = FETCH;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign complete = icache_ren & ~icache_stall;
    // Returns in DRAIN are wrong-path and returns in a redirect cycle are superseded.
    assign push     = complete & (state == FETCH) & ~redirect;
    assign flush    = redirect & (state == FETCH);
    assign load_pc  = redirect & (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            pend    <= 1'b0;
            count   <= 2'd0;
            e0_pc   <= 32'h0;
            e0_inst <= 32'h0;
            e1_pc   <= 32'h0;
            e1_inst <= 32'h0;
        end else begin
            state <= state_nxt;
            pend  <= icache_ren & icache_stall;

            if (icache_ren && !pend)
                req_pc <= pc;

            if (load_pc)
                pc <= pc_nxt & 32'hFFFF_FFFC;
            else if (push)
                pc <= pc + 32'd4;

            if (flush) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            e0_pc   <= cur_req_pc;
                            e0_inst <= icache_rdata;
                        end else begin
                            e1_pc   <= cur_req_pc;
                            e1_inst <= icache_rdata;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        e0_pc   <= e1_pc;
                        e0_inst <= e1_inst;
                        count   <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            e0_pc   <= cur_req_pc;
                            e0_inst <= icache_rdata;
                        end else begin
                            e0_pc   <= e1_pc;
                            e0_inst <= e1_inst;
                            e1_pc   <= cur_req_pc;
                            e1_inst <= icache_rdata;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with decode-order scoreboard
module tb_fetch_unit;

    localparam logic [31:0] K = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_nxt;
    logic        redirect;
    logic [31:0] pc;
    logic        icache_ren;
    logic [29:0] icache_addr;
    logic [31:0] icache_rdata;
    logic        icache_stall;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;

    logic [31:0] b_pc;
    logic        b_ren;
    logic [29:0] b_addr;
    logic [31:0] b_rdata;
    logic        b_valid;
    logic [31:0] b_inst;
    logic [31:0] b_if_pc;

    always #5 clk = ~clk;

    assign icache_rdata = {icache_addr, 2'b00} ^ K;
    assign b_rdata      = {b_addr, 2'b00} ^ K;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_nxt(pc_nxt), .redirect(redirect), .pc(pc),
        .icache_ren(icache_ren), .icache_addr(icache_addr), .icache_rdata(icache_rdata),
        .icache_stall(icache_stall), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
        .id_ready(id_ready)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_nxt(32'h0), .redirect(1'b0), .pc(b_pc),
        .icache_ren(b_ren), .icache_addr(b_addr), .icache_rdata(b_rdata),
        .icache_stall(1'b0), .if_valid(b_valid), .if_inst(b_inst), .if_pc(b_if_pc),
        .id_ready(1'b1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [31:0] exp_q[$];

    task automatic sb_fill(input logic [31:0] base);
        exp_q.delete();
        for (int i = 0; i < 64; i++)
            exp_q.push_back(base + 32'(4 * i));
    endtask

    // Decode-side monitor: every pop must follow the expected program order,
    // and any stalled request must be held unchanged on the next cycle.
    logic        prev_hold = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [31:0] exp_pc;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_ren", 32'(icache_ren), 32'd1);
                check_eq("hold_addr", 32'(icache_addr), 32'(prev_addr));
            end
            if (if_valid && id_ready) begin
                exp_pc = (exp_q.size() != 0) ? exp_q.pop_front() : ~if_pc;
                check_eq("sb_if_pc", if_pc, exp_pc);
                check_eq("sb_if_inst", if_inst, exp_pc ^ K);
            end
            if (redirect)
                sb_fill(pc_nxt & 32'hFFFF_FFFC);
            prev_hold = icache_ren & icache_stall;
            prev_addr = icache_addr;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        rst_n        = 1'b0;
        redirect     = 1'b0;
        pc_nxt       = 32'h0;
        icache_stall = 1'b0;
        id_ready     = rdy;
        repeat (2) cyc();
        sb_fill(32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        redirect     = 1'b0;
        pc_nxt       = 32'h0;
        icache_stall = 1'b0;
        id_ready     = 1'b1;
        sb_fill(32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_ren", 32'(icache_ren), 32'd0);
        check_eq("rst_valid", 32'(if_valid), 32'd0);
        check_eq("rst_inst", if_inst, 32'h0);
        check_eq("rst_if_pc", if_pc, 32'h0);
        check_eq("rst_wrap_pc", b_pc, 32'hFFFF_FFFC);

        // Streaming, stall on 0x8, wrap instance alongside
        do_reset(1'b1);
        smp(); check_eq("idle_ren", 32'(icache_ren), 32'd0);
        cyc(); smp();
        check_eq("c1_ren", 32'(icache_ren), 32'd1);
        check_eq("c1_addr", 32'(icache_addr), 32'd0);
        check_eq("c1_valid", 32'(if_valid), 32'd0);
        check_eq("wrap_addr", 32'(b_addr), 32'h3FFF_FFFF);
        cyc(); smp();
        check_eq("c2_addr", 32'(icache_addr), 32'd1);
        check_eq("c2_if_pc", if_pc, 32'h0);
        check_eq("wrap_if_pc0", b_if_pc, 32'hFFFF_FFFC);
        check_eq("wrap_inst0", b_inst, 32'hFFFF_FFFC ^ K);
        cyc(); icache_stall = 1'b1; smp();
        check_eq("stall_addr0", 32'(icache_addr), 32'd2);
        check_eq("c3_if_pc", if_pc, 32'h4);
        check_eq("wrap_if_pc1", b_if_pc, 32'h0);
        cyc(); smp();
        check_eq("stall_addr1", 32'(icache_addr), 32'd2);
        check_eq("stall_valid1", 32'(if_valid), 32'd0);
        cyc(); smp();
        check_eq("stall_addr2", 32'(icache_addr), 32'd2);
        check_eq("stall_valid2", 32'(if_valid), 32'd0);
        cyc(); icache_stall = 1'b0; smp();
        check_eq("unstall_ren", 32'(icache_ren), 32'd1);
        check_eq("unstall_addr", 32'(icache_addr), 32'd2);
        cyc(); smp();
        check_eq("post_stall_valid", 32'(if_valid), 32'd1);
        check_eq("post_stall_if_pc", if_pc, 32'h8);

        // Reset asserted while a request is stalled
        cyc(); icache_stall = 1'b1;
        cyc();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ren", 32'(icache_ren), 32'd0);
        check_eq("midrst_valid", 32'(if_valid), 32'd0);
        check_eq("midrst_pc", pc, 32'h0);
        check_eq("midrst_if_pc", if_pc, 32'h0);
        check_eq("midrst_inst", if_inst, 32'h0);
        icache_stall = 1'b0;
        cyc();

        // Decode backpressure for 5 cycles
        do_reset(1'b0);
        cyc(); cyc(); cyc(); smp();
        check_eq("bp_ren3", 32'(icache_ren), 32'd0);
        check_eq("bp_valid3", 32'(if_valid), 32'd1);
        check_eq("bp_head3", if_pc, 32'h0);
        cyc(); smp();
        check_eq("bp_ren4", 32'(icache_ren), 32'd0);
        check_eq("bp_head4", if_pc, 32'h0);
        check_eq("bp_inst4", if_inst, 32'h0 ^ K);
        cyc(); id_ready = 1'b1; smp();
        check_eq("bp_pop_ren", 32'(icache_ren), 32'd1);
        check_eq("bp_pop_addr", 32'(icache_addr), 32'd2);
        repeat (3) cyc();

        // Redirect with two entries queued, then misaligned target
        do_reset(1'b0);
        cyc(); cyc(); cyc();
        redirect = 1'b1; pc_nxt = 32'h100; smp();
        check_eq("rd_full_valid", 32'(if_valid), 32'd1);
        cyc(); redirect = 1'b0; id_ready = 1'b1; smp();
        check_eq("rd_valid", 32'(if_valid), 32'd0);
        check_eq("rd_pc", pc, 32'h100);
        check_eq("rd_ren", 32'(icache_ren), 32'd1);
        check_eq("rd_addr", 32'(icache_addr), 32'h40);
        cyc(); smp();
        check_eq("rd_head", if_pc, 32'h100);
        cyc(); redirect = 1'b1; pc_nxt = 32'h103; smp();
        cyc(); redirect = 1'b0; smp();
        check_eq("align_pc", pc, 32'h100);
        check_eq("align_valid", 32'(if_valid), 32'd0);
        cyc(); smp();
        check_eq("align_head", if_pc, 32'h100);
        cyc();

        // Redirect while the fetch of 0x10 is stalled
        do_reset(1'b1);
        repeat (5) cyc();
        icache_stall = 1'b1; smp();
        check_eq("dr_addr0", 32'(icache_addr), 32'h4);
        cyc(); redirect = 1'b1; pc_nxt = 32'h200; smp();
        check_eq("dr_addr1", 32'(icache_addr), 32'h4);
        cyc(); redirect = 1'b0; smp();
        check_eq("dr_ren2", 32'(icache_ren), 32'd1);
        check_eq("dr_addr2", 32'(icache_addr), 32'h4);
        check_eq("dr_pc2", pc, 32'h200);
        check_eq("dr_valid2", 32'(if_valid), 32'd0);
        cyc(); icache_stall = 1'b0; smp();
        check_eq("dr_addr3", 32'(icache_addr), 32'h4);
        cyc(); smp();
        check_eq("dr_new_ren", 32'(icache_ren), 32'd1);
        check_eq("dr_new_addr", 32'(icache_addr), 32'h80);
        check_eq("dr_discard_valid", 32'(if_valid), 32'd0);
        cyc(); smp();
        check_eq("dr_head", if_pc, 32'h200);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
